// File: rtl/itgnet_stream_ctrl.sv
// Raster sequencer feeding the itgnet pipeline: scans a W_HEIGHT x W_WIDTH window, zero-fills blanking
// and flush. Optional ITGNET_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module itgnet_stream_ctrl #(
  parameter int HEIGHT       = -1,
  parameter int WIDTH        = -1,
  parameter int W_HEIGHT     = -1,
  parameter int W_WIDTH      = -1,
  parameter int DATA_BITW    = 8,
  parameter int FLUSH_CYCLES = -1,
  localparam int V_BITW = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1,
  localparam int H_BITW = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [DATA_BITW-1:0] src_data,
  output logic                 out_enable,
  output logic [DATA_BITW-1:0] out_data,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt,
  output logic                 busy,
  output logic                 frame_done
`ifdef ITGNET_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int F_BITW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(W_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(W_WIDTH - 1);
  localparam logic [F_BITW-1:0] F_LAST = F_BITW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  logic [V_BITW-1:0] v_reg;
  logic [H_BITW-1:0] h_reg;
  logic [F_BITW-1:0] fcnt_reg;

  logic              active;
  logic              run_step;
  logic              at_h_end;
  logic              at_last;
  logic [V_BITW-1:0] v_next;
  logic [H_BITW-1:0] h_next;

  assign active    = (int'(v_reg) < HEIGHT) && (int'(h_reg) < WIDTH);
  // Ready depends only on registered state so the source never sees a valid->ready loop.
  assign src_ready = (state == RUN) && active;
  assign run_step  = (state == RUN) && (active ? src_valid : 1'b1);
  assign at_h_end  = (h_reg == H_LAST);
  assign at_last   = at_h_end && (v_reg == V_LAST);
  assign busy      = (state != IDLE);

  always_comb begin
    h_next = h_reg + H_BITW'(1);
    v_next = v_reg;
    if (at_h_end) begin
      h_next = '0;
      v_next = at_last ? '0 : v_reg + V_BITW'(1);
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      v_reg      <= '0;
      h_reg      <= '0;
      fcnt_reg   <= '0;
      out_enable <= 1'b0;
      out_data   <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
      frame_done <= 1'b0;
`ifdef ITGNET_FRAME_CNT_EN
      frame_cnt  <= '0;
`endif
    end else begin
      out_enable <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        v_reg    <= '0;
        h_reg    <= '0;
        fcnt_reg <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= RUN;
              v_reg    <= '0;
              h_reg    <= '0;
              fcnt_reg <= '0;
            end
          end
          RUN: begin
            if (run_step) begin
              out_enable <= 1'b1;
              out_data   <= active ? src_data : '0;
              out_vcnt   <= v_reg;
              out_hcnt   <= h_reg;
              v_reg      <= v_next;
              h_reg      <= h_next;
              if (at_last) state <= FLUSH;
            end
          end
          FLUSH: begin
            out_enable <= 1'b1;
            out_data   <= '0;
            out_vcnt   <= v_reg;
            out_hcnt   <= h_reg;
            if (fcnt_reg == F_LAST) begin
              // Positions are cleared here so the next frame always begins at (0,0).
              frame_done <= 1'b1;
              state      <= IDLE;
              v_reg      <= '0;
              h_reg      <= '0;
              fcnt_reg   <= '0;
`ifdef ITGNET_FRAME_CNT_EN
              frame_cnt  <= frame_cnt + 16'd1;
`endif
            end else begin
              v_reg    <= v_next;
              h_reg    <= h_next;
              fcnt_reg <= fcnt_reg + F_BITW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_itgnet_stream_ctrl.sv
// Directed, table-driven bench for itgnet_stream_ctrl (2x3 image in a 3x4 window, 5 flush cycles).
module tb_itgnet_stream_ctrl;
  localparam int HEIGHT = 2, WIDTH = 3, W_HEIGHT = 3, W_WIDTH = 4, FLUSH_CYCLES = 5, DATA_BITW = 8;
  localparam int NSTROBE = 17;

  logic       clock = 1'b0;
  logic       n_rst, start, abort, src_valid, src_ready;
  logic [7:0] src_data, out_data;
  logic       out_enable, busy, frame_done;
  logic [1:0] out_vcnt, out_hcnt;
`ifdef ITGNET_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  int          exp_fc = 0;
`endif

  always #5 clock = ~clock;

  itgnet_stream_ctrl #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH),
    .DATA_BITW(DATA_BITW), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clock(clock), .n_rst(n_rst), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .out_enable(out_enable), .out_data(out_data), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
    .busy(busy), .frame_done(frame_done)
`ifdef ITGNET_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  typedef struct {bit active; int data; int v; int h; bit fd;} vec_t;
  typedef struct {int data; int v; int h; bit fd; int cyc;} rec_t;

  vec_t       exp_tab [NSTROBE];
  rec_t       q[$];
  logic [7:0] pix [6];
  int         fdc;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  // Runs one frame from a start pulse; returns early at a negedge once stop_at strobes are seen.
  task automatic run_frame(input bit toggle, input bit spam, input int stop_at);
    int  idx = 0;
    bit  hs;
    bit  finished = 0;
    q.delete();
    fdc = 0;
    start = 1'b1;
    src_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      src_valid = toggle ? (c % 2 == 0) : 1'b1;
      src_data  = (idx < 6) ? pix[idx] : 8'hEE;
      start     = spam && (c % 3 == 0) && (q.size() < 15);
      @(negedge clock);
      if (out_enable)
        q.push_back('{int'(out_data), int'(out_vcnt), int'(out_hcnt), frame_done, c});
      if (frame_done) fdc++;
      hs = src_valid && src_ready;
      if (stop_at > 0 && q.size() >= stop_at) begin finished = 1; break; end
      if (fdc > 0 && !busy) begin finished = 1; break; end
      @(posedge clock); #1;
      if (hs) idx++;
    end
    start = 1'b0;
    if (!finished) chk("frame_timeout", 1, 0);
  endtask

  task automatic check_frame(input string name);
    chk({name, "_count"}, q.size(), NSTROBE);
    chk({name, "_frame_done_pulses"}, fdc, 1);
    for (int i = 0; i < NSTROBE; i++) begin
      if (i < q.size()) begin
        chk($sformatf("%s_s%0d_data", name, i), q[i].data, exp_tab[i].data);
        chk($sformatf("%s_s%0d_v", name, i), q[i].v, exp_tab[i].v);
        chk($sformatf("%s_s%0d_h", name, i), q[i].h, exp_tab[i].h);
        chk($sformatf("%s_s%0d_fd", name, i), int'(q[i].fd), int'(exp_tab[i].fd));
      end
    end
    $display("frame %s: strobes=%0d frame_done=%0d", name, q.size(), fdc);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_out_enable"}, int'(out_enable), 0);
    chk({name, "_out_data"}, int'(out_data), 0);
    chk({name, "_out_vcnt"}, int'(out_vcnt), 0);
    chk({name, "_out_hcnt"}, int'(out_hcnt), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_frame_done"}, int'(frame_done), 0);
    chk({name, "_src_ready"}, int'(src_ready), 0);
  endtask

  initial begin
    pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    exp_tab = '{
      '{1, 1, 0, 0, 0}, '{1, 2, 0, 1, 0}, '{1, 3, 0, 2, 0}, '{0, 0, 0, 3, 0},
      '{1, 4, 1, 0, 0}, '{1, 5, 1, 1, 0}, '{1, 6, 1, 2, 0}, '{0, 0, 1, 3, 0},
      '{0, 0, 2, 0, 0}, '{0, 0, 2, 1, 0}, '{0, 0, 2, 2, 0}, '{0, 0, 2, 3, 0},
      '{0, 0, 0, 0, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 2, 0}, '{0, 0, 0, 3, 0},
      '{0, 0, 1, 0, 1}};

    n_rst = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = 8'h00;
    #12;
    check_idle_outputs("reset");
    @(posedge clock); #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("post_reset");

    // Held-valid frame: all strobes back to back.
    run_frame(0, 0, 0);
    check_frame("held");
    if (q.size() == NSTROBE) chk("held_consecutive", q[NSTROBE-1].cyc - q[0].cyc, NSTROBE - 1);
`ifdef ITGNET_FRAME_CNT_EN
    exp_fc++; chk("frame_cnt_1", int'(frame_cnt), exp_fc);
`endif

    // Toggled valid: only active positions may wait for the source.
    run_frame(1, 0, 0);
    check_frame("toggle");
    for (int i = 1; i < NSTROBE; i++) begin
      if (i < q.size() && !exp_tab[i].active)
        chk($sformatf("toggle_nogap_s%0d", i), q[i].cyc - q[i-1].cyc, 1);
    end
`ifdef ITGNET_FRAME_CNT_EN
    exp_fc++; chk("frame_cnt_2", int'(frame_cnt), exp_fc);
`endif

    // Abort while sitting at (1,1).
    run_frame(0, 0, 5);
    chk("abort_partial_count", q.size(), 5);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_enable", int'(out_enable), 0);
    chk("abort_src_ready", int'(src_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("abort_no_done_%0d", i), int'(frame_done || out_enable || busy), 0);
    end
    $display("abort at (1,1): busy=%0d out_enable=%0d", busy, out_enable);
`ifdef ITGNET_FRAME_CNT_EN
    chk("frame_cnt_after_abort", int'(frame_cnt), exp_fc);
`endif
    @(posedge clock); #1;
    run_frame(0, 0, 0);
    check_frame("after_abort");
`ifdef ITGNET_FRAME_CNT_EN
    exp_fc++; chk("frame_cnt_3", int'(frame_cnt), exp_fc);
`endif

    // Start pulses while busy are ignored.
    run_frame(0, 1, 0);
    check_frame("start_spam");
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("spam_stays_idle_%0d", i), int'(busy || out_enable), 0);
    end
`ifdef ITGNET_FRAME_CNT_EN
    exp_fc++; chk("frame_cnt_4", int'(frame_cnt), exp_fc);
`endif

    // start together with abort in IDLE.
    @(posedge clock); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    @(posedge clock); #1;
    chk("start_abort_busy_later", int'(busy), 0);
    chk("start_abort_out_enable", int'(out_enable), 0);
    $display("start+abort in idle: busy=%0d", busy);

    // Asynchronous reset in the middle of flush.
    run_frame(0, 0, 14);
    chk("pre_reset_busy", int'(busy), 1);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("midflush_reset");
    $display("reset mid-flush: out_enable=%0d busy=%0d", out_enable, busy);
`ifdef ITGNET_FRAME_CNT_EN
    exp_fc = 0; chk("frame_cnt_reset", int'(frame_cnt), exp_fc);
`endif
    @(posedge clock); #1;
    n_rst = 1'b1;
    @(posedge clock); #1;
    run_frame(0, 0, 0);
    check_frame("after_reset");
`ifdef ITGNET_FRAME_CNT_EN
    exp_fc++; chk("frame_cnt_5", int'(frame_cnt), exp_fc);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
